// File: rtl/seq_add_sub.sv
// Bit-serial adder/subtractor: one full-adder slice processes one operand bit
// per clock, LSB first, and reports carry-out and signed overflow.
module seq_add_sub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             carry;
  logic             carry_msb;
  logic [CW-1:0]    cnt;
  logic [1:0]       fa;

  // Returns {carry_out, sum_bit} for a single slice.
  function automatic logic [1:0] full_add(input logic x, input logic y, input logic c);
    return {(x & y) | (x & c) | (y & c), x ^ y ^ c};
  endfunction

  assign fa   = full_add(a_sh[0], b_sh[0], carry);
  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (cnt == CW'(WIDTH)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The extra RUN cycle at cnt == WIDTH is where carry-out and overflow are committed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      a_sh      <= '0;
      b_sh      <= '0;
      carry     <= 1'b0;
      carry_msb <= 1'b0;
      cnt       <= '0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= b ^ {WIDTH{mode}};
            carry <= mode;
            cnt   <= '0;
          end
        end
        RUN: begin
          if (cnt != CW'(WIDTH)) begin
            sum   <= {fa[0], sum[WIDTH-1:1]};
            carry <= fa[1];
            a_sh  <= a_sh >> 1;
            b_sh  <= b_sh >> 1;
            cnt   <= cnt + CW'(1);
            if (cnt == CW'(WIDTH - 1)) carry_msb <= carry;
          end else begin
            cout <= carry;
            ovf  <= carry_msb ^ carry;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_add_sub.sv
// Bench for seq_add_sub: vector table, scoreboard-checked results, latency,
// start-ignore, mid-run reset abort, and an exhaustive 4-bit sweep.
module tb_seq_add_sub;

  typedef struct {
    logic [7:0] s;
    logic       c;
    logic       o;
  } exp_t;

  typedef struct {
    bit         m;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] s;
    logic       c;
    logic       o;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start8 = 1'b0, mode8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0, sum8;
  logic       cout8, ovf8, busy8, done8;
  logic       start4 = 1'b0, mode4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0, sum4;
  logic       cout4, ovf4, busy4, done4;

  seq_add_sub #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .mode(mode8), .a(a8), .b(b8),
    .sum(sum8), .cout(cout8), .ovf(ovf8), .busy(busy8), .done(done8)
  );

  seq_add_sub #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .mode(mode4), .a(a4), .b(b4),
    .sum(sum4), .cout(cout4), .ovf(ovf4), .busy(busy4), .done(done4)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   fails = 0;
  int   done8_cnt = 0;
  int   done4_cnt = 0;
  exp_t q8[$];
  exp_t q4[$];

  function automatic exp_t model(int w, bit m, int a, int b);
    int   mask;
    int   bb;
    int   full;
    int   s;
    bit   as, bs, ss;
    exp_t e;
    mask = (1 << w) - 1;
    bb   = m ? (((~b) & mask) + 1) : b;
    full = a + bb;
    s    = full & mask;
    as   = a[w-1];
    bs   = b[w-1];
    ss   = s[w-1];
    e.s  = 8'(s);
    e.c  = full[w];
    e.o  = m ? (as != bs && ss != as) : (as == bs && ss != as);
    return e;
  endfunction

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    @(negedge clk);
    if (done8) begin
      done8_cnt++;
      if (q8.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL done8_unexpected: got sum 0x%0h, expected no done", sum8);
      end else begin
        e = q8.pop_front();
        chk("result8", {sum8, cout8, ovf8}, {e.s, e.c, e.o});
      end
    end
    if (done4) begin
      done4_cnt++;
      if (q4.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL done4_unexpected: got sum 0x%0h, expected no done", sum4);
      end else begin
        e = q4.pop_front();
        chk("result4", {4'h0, sum4, cout4, ovf4}, {e.s, e.c, e.o});
      end
    end
  endtask

  // Called at a negedge with the DUT idle; returns with the DUT idle again.
  task automatic do_op(input bit use4, input bit m, input logic [7:0] a,
                       input logic [7:0] b, input exp_t e);
    int n;
    bit busy_ok;
    bit got;
    int w;
    busy_ok = 1'b1;
    got     = 1'b0;
    w       = use4 ? 4 : 8;
    if (use4) begin
      q4.push_back(e);
      start4 = 1'b1; mode4 = m; a4 = a[3:0]; b4 = b[3:0];
    end else begin
      q8.push_back(e);
      start8 = 1'b1; mode8 = m; a8 = a; b8 = b;
    end
    tick();
    start4 = 1'b0;
    start8 = 1'b0;
    for (n = 1; n <= 40; n++) begin
      if (!(use4 ? busy4 : busy8)) busy_ok = 1'b0;
      tick();
      if (use4 ? done4 : done8) begin
        got = 1'b1;
        break;
      end
    end
    chk("latency", got ? n : -1, w + 1);
    chk("busy_during_run", int'(busy_ok), 1);
    chk("busy_at_done", int'(use4 ? busy4 : busy8), 0);
    tick();
    chk("done_one_cycle", int'(use4 ? done4 : done8), 0);
  endtask

  vec_t vecs[10];
  exp_t e;
  int   cnt0;

  initial begin
    vecs[0] = '{0, 8'hFF, 8'h01, 8'h00, 1, 0};
    vecs[1] = '{0, 8'h7F, 8'h01, 8'h80, 0, 1};
    vecs[2] = '{1, 8'h05, 8'h03, 8'h02, 1, 0};
    vecs[3] = '{1, 8'h03, 8'h05, 8'hFE, 0, 0};
    vecs[4] = '{1, 8'h80, 8'h01, 8'h7F, 1, 1};
    vecs[5] = '{0, 8'h00, 8'h00, 8'h00, 0, 0};
    vecs[6] = '{0, 8'h80, 8'h80, 8'h00, 1, 1};
    vecs[7] = '{1, 8'h00, 8'h00, 8'h00, 1, 0};
    vecs[8] = '{0, 8'h55, 8'hAA, 8'hFF, 0, 0};
    vecs[9] = '{1, 8'h7F, 8'hFF, 8'h80, 0, 1};

    #1 rst = 1'b1;
    #2;
    chk("reset_sum", sum8, 0);
    chk("reset_cout", cout8, 0);
    chk("reset_ovf", ovf8, 0);
    chk("reset_busy", busy8, 0);
    chk("reset_done", done8, 0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 10; i++) begin
      e = '{vecs[i].s, vecs[i].c, vecs[i].o};
      do_op(0, vecs[i].m, vecs[i].a, vecs[i].b, e);
    end
    tick(); tick(); tick();
    chk("hold_sum", sum8, 8'h80);
    chk("hold_cout", cout8, 0);
    chk("hold_ovf", ovf8, 1);

    // start re-pulsed and operands changed mid-run
    cnt0 = done8_cnt;
    q8.push_back(model(8, 0, 8'h12, 8'h34));
    start8 = 1'b1; mode8 = 1'b0; a8 = 8'h12; b8 = 8'h34;
    tick();
    start8 = 1'b0;
    tick(); tick();
    start8 = 1'b1; mode8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF;
    tick();
    start8 = 1'b0;
    for (int i = 0; i < 40 && done8_cnt == cnt0; i++) tick();
    for (int i = 0; i < 12; i++) tick();
    chk("ignore_start_done_count", done8_cnt - cnt0, 1);

    // reset asserted between edges at RUN bit 3
    cnt0 = done8_cnt;
    q8.push_back(model(8, 0, 8'h12, 8'h34));
    start8 = 1'b1; a8 = 8'h12; b8 = 8'h34; mode8 = 1'b0;
    tick();
    start8 = 1'b0;
    tick(); tick(); tick();
    #1 rst = 1'b1;
    q8.delete();
    #1;
    chk("abort_sum", sum8, 0);
    chk("abort_cout", cout8, 0);
    chk("abort_ovf", ovf8, 0);
    chk("abort_busy", busy8, 0);
    chk("abort_done", done8, 0);
    tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < 12; i++) tick();
    chk("no_done_after_abort", done8_cnt - cnt0, 0);
    do_op(0, 0, 8'h10, 8'h20, '{8'h30, 1'b0, 1'b0});

    // start present at an edge while rst is still high
    rst = 1'b1;
    tick();
    start8 = 1'b1; a8 = 8'h01; b8 = 8'h01; mode8 = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    start8 = 1'b0;
    @(negedge clk);
    chk("start_under_rst_ignored", busy8, 0);
    tick();
    chk("start_under_rst_idle", busy8, 0);

    // start held high: two back-to-back operations
    cnt0 = done8_cnt;
    e = model(8, 0, 8'h21, 8'h43);
    q8.push_back(e);
    q8.push_back(e);
    start8 = 1'b1; a8 = 8'h21; b8 = 8'h43; mode8 = 1'b0;
    for (int i = 0; i < 60 && (done8_cnt - cnt0) < 2; i++) tick();
    start8 = 1'b0;
    chk("back_to_back_count", done8_cnt - cnt0, 2);
    tick(); tick();

    for (int m = 0; m < 2; m++)
      for (int a = 0; a < 16; a++)
        for (int b = 0; b < 16; b++)
          do_op(1, m[0], 8'(a), 8'(b), model(4, m[0], a, b));

    chk("q8_drained", q8.size(), 0);
    chk("q4_drained", q4.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
